// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: accepts one request, issues one fixed-length
// INCR burst of 64-bit beats, and reports completion with an error flag.
module axi_burst_master #(
  parameter logic [3:0] AXI_ID      = 4'h0,
  parameter int         BURST_BEATS = 4
) (
  input  logic        axi4_mst_aclk,
  input  logic        axi4_mst_areset,
  // request handshake: a transfer happens on a clock edge where valid && ready
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [30:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        done_valid,
  output logic        done_err,
  output logic [3:0]  axi4_mst_awid,
  output logic [30:0] axi4_mst_awaddr,
  output logic [7:0]  axi4_mst_awlen,
  output logic [2:0]  axi4_mst_awsize,
  output logic [1:0]  axi4_mst_awburst,
  output logic        axi4_mst_awvalid,
  input  logic        axi4_mst_awready,
  output logic [63:0] axi4_mst_wdata,
  output logic [7:0]  axi4_mst_wstrb,
  output logic        axi4_mst_wlast,
  output logic        axi4_mst_wvalid,
  input  logic        axi4_mst_wready,
  input  logic [3:0]  axi4_mst_bid,
  input  logic [1:0]  axi4_mst_bresp,
  input  logic        axi4_mst_bvalid,
  output logic        axi4_mst_bready,
  output logic [3:0]  axi4_mst_arid,
  output logic [30:0] axi4_mst_araddr,
  output logic [7:0]  axi4_mst_arlen,
  output logic [2:0]  axi4_mst_arsize,
  output logic [1:0]  axi4_mst_arburst,
  output logic        axi4_mst_arvalid,
  input  logic        axi4_mst_arready,
  input  logic [3:0]  axi4_mst_rid,
  input  logic [63:0] axi4_mst_rdata,
  input  logic [1:0]  axi4_mst_rresp,
  input  logic        axi4_mst_rlast,
  input  logic        axi4_mst_rvalid,
  output logic        axi4_mst_rready,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } state_t;

  // Aligning to the burst size keeps every burst inside one 4 KB page.
  localparam int          OFF_BITS  = $clog2(BURST_BEATS * 8);
  localparam logic [30:0] ADDR_MASK = ~((31'd1 << OFF_BITS) - 31'd1);
  localparam logic [7:0]  LAST_CNT  = 8'(BURST_BEATS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [30:0] addr_q, addr_d;
  logic        beat_err;
  logic        cnt_last;

  always_ff @(posedge axi4_mst_aclk or posedge axi4_mst_areset) begin
    if (axi4_mst_areset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      addr_q  <= 31'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  assign cnt_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    addr_d           = addr_q;
    beat_err         = 1'b0;
    req_ready        = 1'b0;
    axi4_mst_awvalid = 1'b0;
    axi4_mst_arvalid = 1'b0;
    axi4_mst_wvalid  = 1'b0;
    axi4_mst_wlast   = 1'b0;
    wr_ready         = 1'b0;
    axi4_mst_bready  = 1'b0;
    axi4_mst_rready  = 1'b0;
    rd_valid         = 1'b0;
    rd_last          = 1'b0;
    done_valid       = 1'b0;
    done_err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low during reset so nothing is accepted before release.
        req_ready = !axi4_mst_areset;
        if (req_valid && !axi4_mst_areset) begin
          addr_d  = req_addr & ADDR_MASK;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = req_write ? ST_AW : ST_AR;
        end
      end
      ST_AW: begin
        axi4_mst_awvalid = 1'b1;
        if (axi4_mst_awready) state_d = ST_W;
      end
      ST_W: begin
        axi4_mst_wvalid = wr_valid;
        wr_ready        = axi4_mst_wready;
        axi4_mst_wlast  = cnt_last;
        if (wr_valid && axi4_mst_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_last) state_d = ST_B;
        end
      end
      ST_B: begin
        axi4_mst_bready = 1'b1;
        if (axi4_mst_bvalid) begin
          done_valid = 1'b1;
          done_err   = (axi4_mst_bresp != 2'b00) || (axi4_mst_bid != AXI_ID);
          state_d    = ST_IDLE;
        end
      end
      ST_AR: begin
        axi4_mst_arvalid = 1'b1;
        if (axi4_mst_arready) state_d = ST_R;
      end
      ST_R: begin
        rd_valid        = axi4_mst_rvalid;
        axi4_mst_rready = rd_ready;
        rd_last         = cnt_last;
        if (axi4_mst_rvalid && rd_ready) begin
          // Slave's rlast must agree with our own beat count.
          beat_err = (axi4_mst_rresp != 2'b00) || (axi4_mst_rid != AXI_ID) ||
                     (axi4_mst_rlast != cnt_last);
          err_d    = err_q | beat_err;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_last) begin
            done_valid = 1'b1;
            done_err   = err_q | beat_err;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign axi4_mst_awid    = AXI_ID;
  assign axi4_mst_awaddr  = addr_q;
  assign axi4_mst_awlen   = LAST_CNT;
  assign axi4_mst_awsize  = 3'd3;
  assign axi4_mst_awburst = 2'b01;
  assign axi4_mst_arid    = AXI_ID;
  assign axi4_mst_araddr  = addr_q;
  assign axi4_mst_arlen   = LAST_CNT;
  assign axi4_mst_arsize  = 3'd3;
  assign axi4_mst_arburst = 2'b01;
  assign axi4_mst_wdata   = wr_data;
  assign axi4_mst_wstrb   = wr_strb;
  assign rd_data          = axi4_mst_rdata;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: a 4-beat instance for the main flows and
// a 1-beat instance for the single-beat corner.
module tb_axi_burst_master;
  localparam logic [3:0] ID    = 4'h5;
  localparam int         BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req_valid = 0, req_ready, req_write = 0;
  logic [30:0] req_addr = '0;
  logic wr_valid = 0, wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0] wr_strb = '0;
  logic rd_valid, rd_ready = 0, rd_last;
  logic [63:0] rd_data;
  logic done_valid, done_err;
  logic [3:0] awid, arid, bid = '0, rid = '0;
  logic [30:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize, state_dbg;
  logic [1:0] awburst, arburst, bresp = '0, rresp = '0;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  logic [63:0] wdata, rdata = '0;

  // single-beat instance
  logic s_req_valid = 0, s_req_ready, s_wr_valid = 0, s_wr_ready;
  logic s_req_write = 0;
  logic [30:0] s_req_addr = '0, s_awaddr, s_araddr;
  logic s_rd_valid, s_rd_ready = 0, s_rd_last, s_done_valid, s_done_err;
  logic [63:0] s_rd_data, s_wdata;
  logic [3:0] s_awid, s_arid, s_bid = '0;
  logic [7:0] s_awlen, s_arlen, s_wstrb;
  logic [2:0] s_awsize, s_arsize, s_state_dbg;
  logic [1:0] s_awburst, s_arburst, s_bresp = '0;
  logic s_awvalid, s_awready = 0, s_wlast, s_wvalid, s_wready = 0;
  logic s_bvalid = 0, s_bready, s_arvalid, s_arready = 0, s_rlast = 0, s_rvalid = 0, s_rready;
  logic [63:0] s_wr_data = '0, s_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  axi_burst_master #(.AXI_ID(ID), .BURST_BEATS(BEATS)) dut (
    .axi4_mst_aclk(clk), .axi4_mst_areset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_err(done_err),
    .axi4_mst_awid(awid), .axi4_mst_awaddr(awaddr), .axi4_mst_awlen(awlen),
    .axi4_mst_awsize(awsize), .axi4_mst_awburst(awburst), .axi4_mst_awvalid(awvalid),
    .axi4_mst_awready(awready),
    .axi4_mst_wdata(wdata), .axi4_mst_wstrb(wstrb), .axi4_mst_wlast(wlast),
    .axi4_mst_wvalid(wvalid), .axi4_mst_wready(wready),
    .axi4_mst_bid(bid), .axi4_mst_bresp(bresp), .axi4_mst_bvalid(bvalid), .axi4_mst_bready(bready),
    .axi4_mst_arid(arid), .axi4_mst_araddr(araddr), .axi4_mst_arlen(arlen),
    .axi4_mst_arsize(arsize), .axi4_mst_arburst(arburst), .axi4_mst_arvalid(arvalid),
    .axi4_mst_arready(arready),
    .axi4_mst_rid(rid), .axi4_mst_rdata(rdata), .axi4_mst_rresp(rresp), .axi4_mst_rlast(rlast),
    .axi4_mst_rvalid(rvalid), .axi4_mst_rready(rready),
    .state_dbg(state_dbg)
  );

  axi_burst_master #(.AXI_ID(ID), .BURST_BEATS(1)) dut1 (
    .axi4_mst_aclk(clk), .axi4_mst_areset(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write), .req_addr(s_req_addr),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data), .wr_strb(8'hFF),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data), .rd_last(s_rd_last),
    .done_valid(s_done_valid), .done_err(s_done_err),
    .axi4_mst_awid(s_awid), .axi4_mst_awaddr(s_awaddr), .axi4_mst_awlen(s_awlen),
    .axi4_mst_awsize(s_awsize), .axi4_mst_awburst(s_awburst), .axi4_mst_awvalid(s_awvalid),
    .axi4_mst_awready(s_awready),
    .axi4_mst_wdata(s_wdata), .axi4_mst_wstrb(s_wstrb), .axi4_mst_wlast(s_wlast),
    .axi4_mst_wvalid(s_wvalid), .axi4_mst_wready(s_wready),
    .axi4_mst_bid(s_bid), .axi4_mst_bresp(s_bresp), .axi4_mst_bvalid(s_bvalid),
    .axi4_mst_bready(s_bready),
    .axi4_mst_arid(s_arid), .axi4_mst_araddr(s_araddr), .axi4_mst_arlen(s_arlen),
    .axi4_mst_arsize(s_arsize), .axi4_mst_arburst(s_arburst), .axi4_mst_arvalid(s_arvalid),
    .axi4_mst_arready(s_arready),
    .axi4_mst_rid(ID), .axi4_mst_rdata(s_rdata), .axi4_mst_rresp(2'b00), .axi4_mst_rlast(s_rlast),
    .axi4_mst_rvalid(s_rvalid), .axi4_mst_rready(s_rready),
    .state_dbg(s_state_dbg)
  );

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({req_ready, awvalid, wvalid, bready, arvalid, rready, wr_ready, rd_valid, done_valid,
         s_req_ready, s_awvalid, s_arvalid, s_done_valid} !== 13'd0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero valid/ready exp all 0");
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || s_req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_req_ready: got %b/%b exp 1/1", req_ready, s_req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_write(input logic [30:0] addr, input int aw_delay,
                           input logic [1:0] b_resp, input logic [3:0] b_id);
    logic [63:0] data [BEATS];
    logic [30:0] exp_addr;
    logic [63:0] e;
    logic exp_err;
    int beat, cyc, bdel;
    exp_addr = 31'((addr / (BEATS * 8)) * (BEATS * 8));
    exp_err  = (b_resp != 2'b00) || (b_id != ID);
    for (int i = 0; i < BEATS; i++) begin
      data[i] = {$urandom, $urandom};
      exp_q.push_back(data[i]);
    end
    req_valid = 1; req_write = 1; req_addr = addr;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_req_ready: got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 0; i <= aw_delay; i++) begin
      awready = (i == aw_delay);
      @(negedge clk);
      n_vec++;
      if (awvalid !== 1'b1 || awaddr !== exp_addr) begin
        n_err++; $display("FAIL awaddr: got v=%b %h exp v=1 %h", awvalid, awaddr, exp_addr);
      end
      n_vec++;
      if ({awlen, awsize, awburst, awid} !== {8'(BEATS - 1), 3'd3, 2'b01, ID}) begin
        n_err++; $display("FAIL aw_fields: got %h/%h/%h/%h", awlen, awsize, awburst, awid);
      end
      @(posedge clk); #1;
    end
    awready = 0;
    beat = 0; cyc = 0;
    while (beat < BEATS && cyc < 200) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wready   = ($urandom_range(0, 3) != 0);
      wr_data  = data[beat];
      wr_strb  = 8'($urandom);
      @(negedge clk);
      n_vec++;
      if (wvalid !== wr_valid || wr_ready !== wready || wstrb !== wr_strb || done_valid !== 1'b0) begin
        n_err++; $display("FAIL w_passthru: got wv=%b wrr=%b strb=%h dv=%b exp %b %b %h 0",
                          wvalid, wr_ready, wstrb, done_valid, wr_valid, wready, wr_strb);
      end
      if (wr_valid) begin
        n_vec++;
        if (wlast !== (beat == BEATS - 1)) begin
          n_err++; $display("FAIL wlast: beat %0d got %b exp %b", beat, wlast, beat == BEATS - 1);
        end
      end
      if (wr_valid && wready) begin
        e = exp_q.pop_front();
        n_vec++;
        if (wdata !== e) begin n_err++; $display("FAIL wdata: got %h exp %h", wdata, e); end
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_valid = 0; wready = 0;
    n_vec++;
    if (beat != BEATS) begin n_err++; $display("FAIL w_timeout: got %0d beats exp %0d", beat, BEATS); end
    bdel = $urandom_range(0, 3);
    bresp = b_resp; bid = b_id;
    for (int i = 0; i <= bdel; i++) begin
      bvalid = (i == bdel);
      @(negedge clk);
      n_vec++;
      if (bready !== 1'b1 || done_valid !== (i == bdel)) begin
        n_err++; $display("FAIL b_phase: got bready=%b done=%b exp 1 %b", bready, done_valid, i == bdel);
      end
      if (i == bdel) begin
        n_vec++;
        if (done_err !== exp_err) begin n_err++; $display("FAIL wr_done_err: got %b exp %b", done_err, exp_err); end
      end
      @(posedge clk); #1;
    end
    bvalid = 0;
    @(negedge clk);
    n_vec++;
    if (done_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_after_done: got done=%b req_ready=%b exp 0 1", done_valid, req_ready);
    end
    @(posedge clk); #1;
  endtask

  // err_beat < 0: clean burst; err_kind 1 = bad rresp, 2 = bad rid, 3 = wrong rlast
  task automatic run_read(input logic [30:0] addr, input int err_beat, input int err_kind,
                          input bit toggle);
    logic [63:0] data [BEATS];
    logic [30:0] exp_addr;
    logic [63:0] e;
    logic exp_err;
    int beat, cyc, adel;
    exp_addr = 31'((addr / (BEATS * 8)) * (BEATS * 8));
    exp_err  = (err_beat >= 0);
    for (int i = 0; i < BEATS; i++) begin
      data[i] = {$urandom, $urandom};
      exp_q.push_back(data[i]);
    end
    req_valid = 1; req_write = 0; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 0;
    adel = $urandom_range(0, 2);
    for (int i = 0; i <= adel; i++) begin
      arready = (i == adel);
      @(negedge clk);
      n_vec++;
      if (arvalid !== 1'b1 || araddr !== exp_addr || arlen !== 8'(BEATS - 1) || arid !== ID) begin
        n_err++; $display("FAIL araddr: got v=%b %h len=%h id=%h exp %h", arvalid, araddr, arlen, arid, exp_addr);
      end
      @(posedge clk); #1;
    end
    arready = 0;
    beat = 0; cyc = 0;
    while (beat < BEATS && cyc < 200) begin
      rvalid   = ($urandom_range(0, 2) != 0);
      rdata    = data[beat];
      rresp    = (beat == err_beat && err_kind == 1) ? 2'b10 : 2'b00;
      rid      = (beat == err_beat && err_kind == 2) ? ~ID : ID;
      rlast    = (beat == BEATS - 1) ^ (beat == err_beat && err_kind == 3);
      rd_ready = toggle ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_vec++;
      if (rready !== rd_ready || rd_valid !== rvalid) begin
        n_err++; $display("FAIL r_passthru: got rready=%b rd_valid=%b exp %b %b", rready, rd_valid, rd_ready, rvalid);
      end
      if (rvalid && rd_ready) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data !== e || rd_last !== (beat == BEATS - 1)) begin
          n_err++; $display("FAIL rd_beat: beat %0d got %h last=%b exp %h last=%b", beat, rd_data, rd_last, e, beat == BEATS - 1);
        end
        n_vec++;
        if (done_valid !== (beat == BEATS - 1)) begin
          n_err++; $display("FAIL rd_done: beat %0d got %b exp %b", beat, done_valid, beat == BEATS - 1);
        end
        if (beat == BEATS - 1) begin
          n_vec++;
          if (done_err !== exp_err) begin n_err++; $display("FAIL rd_done_err: got %b exp %b", done_err, exp_err); end
        end
        beat++;
      end else begin
        n_vec++;
        if (done_valid !== 1'b0) begin n_err++; $display("FAIL rd_spurious_done: got 1 exp 0"); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (beat != BEATS || exp_q.size() != 0) begin
      n_err++; $display("FAIL r_count: got %0d beats exp %0d", beat, BEATS);
    end
    // stray responses while idle must not be acknowledged
    rvalid = 1; bvalid = 1; rd_ready = 1;
    @(negedge clk);
    n_vec++;
    if ({rready, bready, rd_valid, done_valid, req_ready} !== 5'b00001) begin
      n_err++; $display("FAIL idle_ignore: got %b exp 00001", {rready, bready, rd_valid, done_valid, req_ready});
    end
    @(posedge clk); #1;
    rvalid = 0; bvalid = 0; rd_ready = 0; rresp = 0; rid = ID; rlast = 0;
  endtask

  task automatic test_write_basic();
    run_write(31'h100, 3, 2'b00, ID);
  endtask

  task automatic test_read_basic();
    run_read(31'h11C, -1, 0, 1'b0);
  endtask

  task automatic test_read_rresp_err();
    run_read(31'h240, 1, 1, 1'b0);
  endtask

  task automatic test_read_toggle();
    run_read(31'h3F8, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    req_valid = 1; req_write = 1; req_addr = 31'h500;
    @(posedge clk); #1;
    req_valid = 0; awready = 1;
    @(posedge clk); #1;
    awready = 0; wr_valid = 1; wready = 1; wr_data = 64'h1111;
    cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done_valid) cnt++;
    end
    rst = 1;
    #1;
    n_vec++;
    if ({awvalid, wvalid, bready, arvalid, rready, wr_ready, rd_valid, done_valid, req_ready} !== 9'd0) begin
      n_err++; $display("FAIL mid_reset_outputs: got nonzero exp all 0");
    end
    wr_valid = 0; wready = 0;
    @(negedge clk);
    if (done_valid) cnt++;
    rst = 0;
    @(posedge clk); #1;
    if (done_valid) cnt++;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || cnt != 0) begin
      n_err++; $display("FAIL mid_reset_idle: got req_ready=%b dones=%0d exp 1 0", req_ready, cnt);
    end
    @(posedge clk); #1;
    exp_q.delete();
    run_write(31'h508, 0, 2'b00, ID);
  endtask

  task automatic test_single_beat();
    s_req_valid = 1; s_req_write = 1; s_req_addr = 31'h10C;
    @(posedge clk); #1;
    s_req_valid = 0; s_awready = 1;
    @(negedge clk);
    n_vec++;
    if (s_awaddr !== 31'h108 || s_awlen !== 8'd0) begin
      n_err++; $display("FAIL single_aw: got %h len %h exp 108 00", s_awaddr, s_awlen);
    end
    @(posedge clk); #1;
    s_awready = 0; s_wr_valid = 1; s_wready = 1; s_wr_data = {$urandom, $urandom};
    @(negedge clk);
    n_vec++;
    if (s_wvalid !== 1'b1 || s_wlast !== 1'b1 || s_wdata !== s_wr_data) begin
      n_err++; $display("FAIL single_wlast: got v=%b last=%b exp 1 1", s_wvalid, s_wlast);
    end
    @(posedge clk); #1;
    s_wr_valid = 0; s_wready = 0; s_bvalid = 1; s_bid = ID ^ 4'h3; s_bresp = 2'b00;
    @(negedge clk);
    n_vec++;
    if (s_done_valid !== 1'b1 || s_done_err !== 1'b1) begin
      n_err++; $display("FAIL single_bid_err: got done=%b err=%b exp 1 1", s_done_valid, s_done_err);
    end
    @(posedge clk); #1;
    s_bvalid = 0;
    s_req_valid = 1; s_req_write = 0; s_req_addr = 31'h2F;
    @(posedge clk); #1;
    s_req_valid = 0; s_arready = 1;
    @(posedge clk); #1;
    s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rd_ready = 1; s_rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    n_vec++;
    if (s_rd_last !== 1'b1 || s_done_valid !== 1'b1 || s_done_err !== 1'b0 || s_rd_data !== s_rdata) begin
      n_err++; $display("FAIL single_read: got last=%b done=%b err=%b exp 1 1 0", s_rd_last, s_done_valid, s_done_err);
    end
    @(posedge clk); #1;
    s_rvalid = 0; s_rlast = 0; s_rd_ready = 0;
  endtask

  task automatic test_random();
    logic [30:0] a;
    for (int n = 0; n < 8; n++) begin
      a = 31'($urandom);
      if ($urandom_range(0, 1) == 1)
        run_write(a, $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00,
                  ($urandom_range(0, 3) == 0) ? ~ID : ID);
      else
        run_read(a, $urandom_range(0, 4) - 1, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rid = ID;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_rresp_err();
    test_read_toggle();
    test_reset_mid_burst();
    test_single_beat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, the ID driven on AW/AR and expected on B/R.
REQ-002 SHALL have parameter BURST_BEATS, default 4, the beats per burst; legal values are powers of two from 1 to 256.
REQ-003 SHALL have port axi4_mst_aclk, in, 1, the single clock for all logic.
REQ-004 SHALL have port axi4_mst_areset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports req_valid/req_ready (in/out, 1/1), the request handshake.
REQ-006 SHALL have ports req_write (in, 1) and req_addr (in, 31): 1 = write burst, and the byte address.
REQ-007 SHALL have ports wr_valid/wr_ready (in/out, 1/1) and wr_data/wr_strb (in, 64/8), the write-beat source.
REQ-008 SHALL have ports rd_valid/rd_ready (out/in, 1/1) and rd_data/rd_last (out, 64/1), the read-beat sink.
REQ-009 SHALL have ports done_valid (out, 1) and done_err (out, 1), the burst-completion pulse and its error flag.
REQ-010 SHALL have AXI4 master ports axi4_mst_aw{id,addr,len,size,burst,valid}, out, 4/31/8/3/2/1, and axi4_mst_awready, in, 1.
REQ-011 SHALL have AXI4 master ports axi4_mst_w{data,strb,last,valid}, out, 64/8/1/1, and axi4_mst_wready, in, 1.
REQ-012 SHALL have AXI4 master ports axi4_mst_b{id,resp,valid}, in, 4/2/1, and axi4_mst_bready, out, 1.
REQ-013 SHALL have AXI4 master ports axi4_mst_ar{id,addr,len,size,burst,valid}, out, 4/31/8/3/2/1, and axi4_mst_arready, in, 1.
REQ-014 SHALL have AXI4 master ports axi4_mst_r{id,data,resp,last,valid}, in, 4/64/2/1/1, and axi4_mst_rready, out, 1.

Function
REQ-015 SHALL implement FSM states IDLE, AW, W, B, AR, R, with one burst outstanding at a time.
REQ-016 SHALL assert req_ready only in IDLE; on req_valid&&req_ready it SHALL latch the request, go to AW if req_write=1, else go to AR.
REQ-017 SHALL form aw/araddr from the latched address with the low log2(BURST_BEATS*8) bits cleared, so no burst crosses a 4 KB boundary.
REQ-018 SHALL drive len=BURST_BEATS-1, size=3'd3, burst=2'b01 (INCR), and id=AXI_ID.
REQ-019 In AW/AR it SHALL hold awvalid/arvalid high with stable fields until ready, then move to W/R respectively.
REQ-020 In W it SHALL pass through wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wstrb=wr_strb.
REQ-021 In W it SHALL use an 8-bit beat counter (cleared on entry) that increments per wvalid&&wready; wlast=1 when count==BURST_BEATS-1; on the last beat it SHALL go to B.
REQ-022 In B it SHALL hold bready=1; on bvalid it SHALL pulse done_valid for 1 cycle with done_err=(bresp!=0)||(bid!=AXI_ID), then go to IDLE.
REQ-023 In R it SHALL pass through rd_valid=rvalid, rready=rd_ready, rd_data=rdata, with rd_last=1 when count==BURST_BEATS-1.
REQ-024 In R it SHALL accumulate a sticky error flag over all beats: any rresp!=0, any rid!=AXI_ID, or rlast!=(count==BURST_BEATS-1).
REQ-025 On the last R beat (count==BURST_BEATS-1) it SHALL pulse done_valid with done_err set to the sticky flag and go to IDLE; the flag SHALL clear on leaving IDLE.
REQ-026 Outside their states, awvalid, wvalid, bready, arvalid, rready, wr_ready, rd_valid and done_valid SHALL be 0.
REQ-027 A bvalid or rvalid outside B/R SHALL be ignored (no ready, no state change).
REQ-028 For BURST_BEATS=1, wlast and rd_last SHALL be 1 on the single beat.

Reset
REQ-029 While axi4_mst_areset=1, the block SHALL asynchronously force IDLE, counters=0, error=0, and all valid/ready outputs=0 (req_ready goes to 1 after release).
REQ-030 Reset mid-burst SHALL abandon the burst without emitting done_valid; the downstream slave is reset together with it.

Verification
REQ-031 Write, addr=31'h100, 4 beats, awready delayed 3 cycles -> awaddr=31'h100, awlen=3, wlast on beat 3 only, one done_valid with done_err=0.
REQ-032 Read, addr=31'h11C -> araddr=31'h100; 4 rd beats, rd_last on the 4th, done_err=0.
REQ-033 Read with rresp=2'b10 on beat 1 -> all 4 beats still delivered, done_err=1.
REQ-034 rd_ready toggling 0/1 each cycle -> rready mirrors rd_ready, no beat lost or duplicated.
REQ-035 Reset asserted during W beat 2 -> next cycle all valids=0, state IDLE, no done_valid; a new write then completes normally.
REQ-036 BURST_BEATS=1 write with bid!=AXI_ID -> wlast=1 on the only beat, done_err=1.
